// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU scanline buffer.
//   LINE_W, AW   : default scanline depth and matching address width
//   PAL_ENTRIES  : palette RAM depth
//   bank_state_t : lifecycle of one line bank
//   pal_mirror() : folds the sprite backdrop aliases 10/14/18/1C onto 00/04/08/0C
package ppu_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned AW          = 8;
  localparam int unsigned PAL_ENTRIES = 32;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  function automatic logic [4:0] pal_mirror(input logic [4:0] addr);
    if (addr[4] && (addr[1:0] == 2'b00)) begin
      return {1'b0, addr[3:0]};
    end
    return addr;
  endfunction

endpackage

// File: rtl/ppu_palette_ram.sv
// 32x6 palette RAM with mirrored addressing on both ports.
//   clk, reset : clock, async active-high reset (clears only the read register)
//   we/waddr/wdata : write port
//   re/raddr       : read request; rdata updates the cycle after re
//   rdata          : registered palette entry
// A same-cycle write and read of one entry returns the old contents.
module ppu_palette_ram (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [5:0] wdata,
  input  logic       re,
  input  logic [4:0] raddr,
  output logic [5:0] rdata
);
  import ppu_pkg::*;

  logic [5:0] mem [PAL_ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[pal_mirror(waddr)] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[pal_mirror(raddr)];
    end
  end

endmodule

// File: rtl/ppu_line_buffer.sv
// Ping-pong scanline buffer between the background renderer and VGA output.
//   clk, reset                 : clock, async active-high reset
//   wr_valid, wr_pix, wr_line_end, wr_ready : renderer side (5-bit palette addresses)
//   rd_start, rd_en            : VGA side line start and pixel request
//   color_idx, color_valid     : 6-bit NES colour, valid one cycle after rd_en
//   pal_we, pal_addr, pal_wdata: palette write port
//   underrun, overflow         : sticky error flags
module ppu_line_buffer #(
  parameter int unsigned LINE_W = ppu_pkg::LINE_W,
  parameter int unsigned AW     = ppu_pkg::AW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [4:0] wr_pix,
  input  logic       wr_line_end,
  output logic       wr_ready,
  input  logic       rd_start,
  input  logic       rd_en,
  output logic [5:0] color_idx,
  output logic       color_valid,
  input  logic       pal_we,
  input  logic [4:0] pal_addr,
  input  logic [5:0] pal_wdata,
  output logic       underrun,
  output logic       overflow
);
  import ppu_pkg::*;

  localparam logic [AW:0] PTR_END  = (AW+1)'(LINE_W);
  localparam logic [AW:0] PTR_LAST = (AW+1)'(LINE_W - 1);

  logic [4:0] bank0_mem [LINE_W];
  logic [4:0] bank1_mem [LINE_W];

  bank_state_t bank_st_q [2];
  bank_state_t bank_st_d [2];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_ready_q, wr_ready_d;
  logic        underrun_q, underrun_d;
  logic        overflow_q, overflow_d;
  logic        has_line_q, has_line_d;
  logic        color_valid_q;

  logic        wr_accept;
  logic        line_close;
  logic [AW-1:0] rd_addr;
  logic [4:0]  rd_pix;
  logic [4:0]  pal_ridx;

  always_comb begin
    bank_st_d  = bank_st_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ready_d = wr_ready_q;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    has_line_d = has_line_q;

    wr_accept  = wr_valid && wr_ready_q && (wr_ptr_q != PTR_END);
    line_close = wr_line_end && wr_ready_q;

    if (wr_valid && !wr_accept) begin
      overflow_d = 1'b1;
    end
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    // Close the line before the read claim so a same-cycle rd_start
    // picks up the bank that is completing right now.
    if (line_close) begin
      bank_st_d[wr_bank_q] = FULL;
      wr_ptr_d             = '0;
    end

    if (rd_start) begin
      rd_ptr_d = '0;
      if (bank_st_d[~rd_bank_q] == FULL) begin
        if (bank_st_d[rd_bank_q] == DRAINING) begin
          bank_st_d[rd_bank_q] = EMPTY;
        end
        bank_st_d[~rd_bank_q] = DRAINING;
        rd_bank_d             = ~rd_bank_q;
        has_line_d            = 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
    end else if (rd_en && (rd_ptr_q != PTR_END)) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if ((rd_ptr_q == PTR_LAST) && (bank_st_d[rd_bank_q] == DRAINING)) begin
        bank_st_d[rd_bank_q] = EMPTY;
      end
    end

    // Writer switch sees the bank freed by the read side in this same cycle.
    if (line_close || !wr_ready_q) begin
      if (bank_st_d[~wr_bank_q] == EMPTY) begin
        wr_bank_d  = ~wr_bank_q;
        wr_ready_d = 1'b1;
      end else begin
        wr_ready_d = 1'b0;
      end
    end
    if (wr_ready_d && (bank_st_d[wr_bank_d] == EMPTY)) begin
      bank_st_d[wr_bank_d] = FILLING;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_st_q     <= '{EMPTY, EMPTY};
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wr_ready_q    <= 1'b1;
      underrun_q    <= 1'b0;
      overflow_q    <= 1'b0;
      has_line_q    <= 1'b0;
      color_valid_q <= 1'b0;
    end else begin
      bank_st_q     <= bank_st_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ready_q    <= wr_ready_d;
      underrun_q    <= underrun_d;
      overflow_q    <= overflow_d;
      has_line_q    <= has_line_d;
      color_valid_q <= rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept && !reset) begin
      if (wr_bank_q) begin
        bank1_mem[wr_ptr_q[AW-1:0]] <= wr_pix;
      end else begin
        bank0_mem[wr_ptr_q[AW-1:0]] <= wr_pix;
      end
    end
  end

  // Pointer past the end keeps returning the last pixel of the line.
  always_comb begin
    rd_addr = rd_ptr_q[AW] ? '1 : rd_ptr_q[AW-1:0];
    if (!has_line_q) begin
      rd_pix = '0;
    end else if (rd_bank_q) begin
      rd_pix = bank1_mem[rd_addr];
    end else begin
      rd_pix = bank0_mem[rd_addr];
    end
    pal_ridx = (rd_pix[1:0] == 2'b00) ? '0 : rd_pix;
  end

  ppu_palette_ram u_pal (
    .clk   (clk),
    .reset (reset),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_wdata),
    .re    (rd_en),
    .raddr (pal_ridx),
    .rdata (color_idx)
  );

  assign wr_ready    = wr_ready_q;
  assign color_valid = color_valid_q;
  assign underrun    = underrun_q;
  assign overflow    = overflow_q;

endmodule
